// File: rtl/uart_rcv_if.sv
// Purpose: parallel side of the UART receiver: serial line in, received byte, status flags.
// Latency: none, wires only.
// Backpressure: none; the consumer acknowledges with clr_rdy and the receiver never stalls.
//
// Signals:
//   RX       serial line into the receiver, idle high
//   clr_rdy  consumer acknowledge, clears rdy and frm_err
//   rx_data  last correctly framed byte
//   rdy      new byte available on rx_data (sticky)
//   frm_err  last frame had a low stop bit (sticky)
interface uart_rcv_if;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    // slave: the receiver itself
    modport slave (
        input  RX,
        input  clr_rdy,
        output rx_data,
        output rdy,
        output frm_err
    );

    // master: line driver plus byte consumer
    modport master (
        output RX,
        output clr_rdy,
        input  rx_data,
        input  rdy,
        input  frm_err
    );
endinterface

// File: rtl/uart_rcv.sv
// Purpose: 8N1 UART receiver (LSB first, idle high); recovers bytes from the async RX pin.
// Latency: flags and byte appear 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks after RX falls.
// Backpressure: none; rdy/frm_err are sticky until clr_rdy or the next start edge.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   uart_rcv_if.slave: RX, clr_rdy in; rx_data, rdy, frm_err out
module uart_rcv #(
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic        clk,
    input  logic        rst,
    uart_rcv_if.slave   bus
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t        state;
    logic          rx_s1;
    logic          rx_s2;
    logic          rx_prev;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shift_reg;
    logic [7:0]    rx_data_q;
    logic          rdy_q;
    logic          frm_err_q;

    logic          fall;
    logic          sample_now;
    logic          frame_ok;

    // Start detection needs a real high->low transition on the synchronized line,
    // so a line parked low (e.g. after a framing error) cannot re-arm the receiver.
    assign fall       = rx_prev & ~rx_s2;
    assign sample_now = (baud_cnt == CNT_ONE);
    // At the stop sample the start bit still sits in shift_reg[0]; requiring it low
    // alongside a high stop bit keeps the framing check self-contained.
    assign frame_ok   = rx_s2 & ~shift_reg[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data_q <= '0;
            rdy_q     <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            rx_s1   <= bus.RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;

            // Acknowledge first; any flag set below in the same cycle overrides it.
            if (bus.clr_rdy) begin
                rdy_q     <= 1'b0;
                frm_err_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        baud_cnt  <= HALF_BIT;
                        bit_cnt   <= '0;
                        rdy_q     <= 1'b0;
                        frm_err_q <= 1'b0;
                        state     <= RECV;
                    end
                end
                RECV: begin
                    if (sample_now) begin
                        baud_cnt  <= FULL_BIT;
                        bit_cnt   <= bit_cnt + 4'd1;
                        shift_reg <= {rx_s2, shift_reg[8:1]};
                        if (bit_cnt == 4'd0) begin
                            // Start bit high at mid-bit: noise, not a frame.
                            if (rx_s2) begin
                                state <= IDLE;
                            end
                        end else if (bit_cnt == 4'd9) begin
                            // Samples 1..8 now occupy shift_reg[8:1], bit 0 at [1].
                            state <= IDLE;
                            if (frame_ok) begin
                                rx_data_q <= shift_reg[8:1];
                                rdy_q     <= 1'b1;
                            end else begin
                                frm_err_q <= 1'b1;
                            end
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_data = rx_data_q;
    assign bus.rdy     = rdy_q;
    assign bus.frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_rcv.sv
// Bench for uart_rcv: unit 0 runs at 16 clocks/bit (directed + random traffic),
// unit 1 runs at the default 2604 clocks/bit (back-to-back loopback bytes).
// A timing model predicts {rdy, frm_err, rx_data} every cycle for both units.
module tb_uart_rcv;

    localparam int C0 = 16;
    localparam int C1 = 2604;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;
    bit done0  = 1'b0;
    bit done1  = 1'b0;
    bit rand_on = 1'b0;

    logic rst0 = 1'b1, rst1 = 1'b1;
    logic rx0  = 1'b1, rx1  = 1'b1;
    logic clr0 = 1'b0, clr1 = 1'b0;

    uart_rcv_if if0 ();
    uart_rcv_if if1 ();
    assign if0.RX      = rx0;
    assign if0.clr_rdy = clr0;
    assign if1.RX      = rx1;
    assign if1.clr_rdy = clr1;

    uart_rcv #(.CLKS_PER_BIT(C0)) dut0 (.clk(clk), .rst(rst0), .bus(if0.slave));
    uart_rcv #(.CLKS_PER_BIT(C1)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

    logic [9:0] dut_out [2];
    assign dut_out[0] = {if0.rdy, if0.frm_err, if0.rx_data};
    assign dut_out[1] = {if1.rdy, if1.frm_err, if1.rx_data};

    function automatic int cpb(input int i);
        return (i == 0) ? C0 : C1;
    endfunction

    // ---------------- behavioural model ----------------
    // Works from the line as seen two clocks late, and from the elapsed time since
    // the detected start edge: sample k falls at t = CPB/2 + k*CPB.
    bit       m_busy [2];
    int       m_t    [2];
    bit [7:0] m_bits [2];
    bit       m_rdy  [2];
    bit       m_err  [2];
    bit [7:0] m_data [2];
    bit       m_h    [2][3];   // line value 3, 2, 1 clocks ago

    function automatic logic [9:0] m_out(input int i);
        return {m_rdy[i], m_err[i], m_data[i]};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit rst_now, rx_now, clr_now, fall, line, set_r, set_e;
            int half, per, k;
            rst_now = (i == 0) ? rst0 : rst1;
            rx_now  = (i == 0) ? rx0  : rx1;
            clr_now = (i == 0) ? clr0 : clr1;
            per  = cpb(i);
            half = per / 2;
            if (rst_now) begin
                m_busy[i] = 0; m_t[i] = 0; m_bits[i] = 0;
                m_rdy[i] = 0; m_err[i] = 0; m_data[i] = 0;
                m_h[i][0] = 1; m_h[i][1] = 1; m_h[i][2] = 1;
            end else begin
                fall  = m_h[i][0] & ~m_h[i][1];
                line  = m_h[i][1];
                set_r = 0;
                set_e = 0;
                if (!m_busy[i]) begin
                    if (fall) begin
                        m_busy[i] = 1; m_t[i] = 0;
                        m_rdy[i] = 0; m_err[i] = 0;
                    end
                end else begin
                    m_t[i]++;
                    if (m_t[i] >= half && (m_t[i] - half) % per == 0) begin
                        k = (m_t[i] - half) / per;
                        if (k == 0) begin
                            if (line) m_busy[i] = 0;
                        end else if (k <= 8) begin
                            m_bits[i][k-1] = line;
                        end else begin
                            m_busy[i] = 0;
                            if (line) begin set_r = 1; m_data[i] = m_bits[i]; end
                            else set_e = 1;
                        end
                    end
                end
                if (clr_now) begin
                    if (!set_r) m_rdy[i] = 0;
                    if (!set_e) m_err[i] = 0;
                end
                if (set_r) m_rdy[i] = 1;
                if (set_e) m_err[i] = 1;
                m_h[i][0] = m_h[i][1];
                m_h[i][1] = m_h[i][2];
                m_h[i][2] = rx_now;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Literal expectation applied to both the DUT and the model.
    task automatic pin(input string name, input int i, input logic [9:0] exp);
        chk({name, "_dut"}, 32'(dut_out[i]), 32'(exp));
        chk({name, "_model"}, 32'(m_out(i)), 32'(exp));
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int i = 0; i < 2; i++)
                chk($sformatf("cyc%0d_u%0d", cyc, i), 32'(dut_out[i]), 32'(m_out(i)));
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_rx(input int i, input logic v);
        if (i == 0) rx0 = v; else rx1 = v;
    endtask

    task automatic set_clr(input int i, input logic v);
        if (i == 0) clr0 = v; else clr1 = v;
    endtask

    task automatic send(input int i, input logic [7:0] b, input logic stop, input int per);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            set_rx(i, fr[k]);
            tick(per);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick(1);
    endtask

    // ---------------- unit 0: 16 clocks/bit ----------------
    initial begin
        tick(3);
        rst0 = 1'b0;
        tick(1);
        pin("reset_u0", 0, 10'h000);

        // RX drops 1ns after edge e0; rdy registers at edge e0+155 and is high
        // for the whole 156th clock counted from the drop.
        fork
            send(0, 8'hA5, 1'b1, C0);
            begin
                tick(154);
                pin("a5_before_rdy", 0, {1'b0, 1'b0, 8'h00});
                tick(1);
                pin("a5_rdy", 0, {1'b1, 1'b0, 8'hA5});
            end
        join
        set_clr(0, 1'b1); tick(1); set_clr(0, 1'b0);
        pin("a5_clr", 0, {1'b0, 1'b0, 8'hA5});

        // False start: low for 4 clocks only.
        set_rx(0, 1'b0); tick(4); set_rx(0, 1'b1); tick(40);
        pin("false_start", 0, {1'b0, 1'b0, 8'hA5});

        // Framing error, then line parked low.
        send(0, 8'h3C, 1'b0, C0);
        pin("frm_err", 0, {1'b0, 1'b1, 8'hA5});
        tick(100);
        pin("held_low", 0, {1'b0, 1'b1, 8'hA5});
        set_rx(0, 1'b1); tick(32);
        fork
            send(0, 8'h81, 1'b1, C0);
            begin
                tick(2);
                pin("err_before_start", 0, {1'b0, 1'b1, 8'hA5});
                tick(2);
                pin("err_cleared_at_start", 0, {1'b0, 1'b0, 8'hA5});
            end
        join
        pin("rx_81", 0, {1'b1, 1'b0, 8'h81});

        // Reset pulse in the middle of data bit 4 of 8'hF0 (line high from bit 4 on).
        set_rx(0, 1'b0); tick(5 * C0);
        set_rx(0, 1'b1); tick(C0 / 2);
        rst0 = 1'b1; tick(1); rst0 = 1'b0;
        pin("rst_mid_frame", 0, 10'h000);
        tick(C0 / 2 - 1 + 4 * C0);
        tick(200);
        pin("no_rdy_after_rst", 0, 10'h000);
        send(0, 8'h7E, 1'b1, C0);
        pin("rx_7E", 0, {1'b1, 1'b0, 8'h7E});

        // Random traffic: bytes, stop bits, slightly off bit periods, false starts,
        // idle gaps (including none) and random acknowledges.
        rand_on = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 4);
            if (kind == 4) begin
                set_rx(0, 1'b0);
                tick($urandom_range(1, C0 - 1));
                set_rx(0, 1'b1);
                tick(C0);
            end else begin
                send(0, 8'($urandom), ($urandom_range(0, 5) != 0), $urandom_range(C0 - 1, C0 + 1));
            end
            set_rx(0, 1'b1);
            tick($urandom_range(0, 40));
        end
        rand_on = 1'b0;
        tick(2 * 10 * C0);
        done0 = 1'b1;
    end

    initial begin
        wait (rand_on);
        while (rand_on) begin
            set_clr(0, ($urandom_range(0, 7) == 0));
            tick(1);
        end
        set_clr(0, 1'b0);
    end

    // ---------------- unit 1: default rate, back-to-back loopback ----------------
    initial begin
        int d0, s;
        tick(3);
        rst1 = 1'b0;
        tick(1);
        pin("reset_u1", 1, 10'h000);
        tick(5);
        d0 = cyc;
        fork
            begin
                send(1, 8'h00, 1'b1, C1);
                send(1, 8'hFF, 1'b1, C1);
                send(1, 8'h55, 1'b1, C1);
            end
            begin
                s = d0 + 3 + C1 / 2 + 9 * C1;
                wait_cyc(s - 1);
                set_clr(1, 1'b1); tick(1); set_clr(1, 1'b0);
                pin("set_wins_00", 1, {1'b1, 1'b0, 8'h00});
                s = s + 10 * C1;
                wait_cyc(s - 1);
                pin("pre_FF", 1, {1'b0, 1'b0, 8'h00});
                tick(1);
                pin("rx_FF", 1, {1'b1, 1'b0, 8'hFF});
                tick(50);
                set_clr(1, 1'b1); tick(1); set_clr(1, 1'b0);
                pin("clr_FF", 1, {1'b0, 1'b0, 8'hFF});
                s = s + 10 * C1;
                wait_cyc(s);
                pin("rx_55", 1, {1'b1, 1'b0, 8'h55});
            end
        join
        tick(10);
        done1 = 1'b1;
    end

    // ---------------- end of run ----------------
    initial begin
        wait (done0 && done1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #(95000 * 10);
        checks++;
        fails++;
        $display("FAIL watchdog actual=not_done required=done_by_95000_cycles");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_rcv.md
# uart_rcv

Serial UART receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line. It recovers bytes sent by the team's UART transmitter and presents them on a parallel port with a ready flag. Default bit period is 2604 clocks, the same rate the transmitter uses, so a loopback of the two needs no configuration. It sits between the asynchronous RX pin and the command/data consumer logic.

## Interface
- CLKS_PER_BIT, 2604: clocks per bit period; must be ≥ 4. The counter width is $clog2(CLKS_PER_BIT)+1.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- RX  input  1  asynchronous serial line; idle is high.
- clr_rdy  input  1  consumer acknowledge; clears rdy and frm_err.
- rx_data  output  8  last correctly framed byte.
- rdy  output  1  a new byte is available on rx_data.
- frm_err  output  1  the last frame had a low stop bit; the byte was discarded.

## Operation
- Synchronizer: two flops (rx_s1, rx_s2) followed by an edge flop (rx_prev). All three reset to 1.
  - fall = rx_prev & ~rx_s2.
  - RX is never used directly.
- Counters:
  - baud_cnt: down-counter.
  - bit_cnt: 4 bits, counts 0..9.
  - shift_reg: 9 bits. Each sample shifts in at the MSB and shifts right.
- FSM has 2 states; reset state is IDLE.
  - IDLE:
    - Leave IDLE only on fall; a line that is merely low does not start a frame.
    - On fall: load baud_cnt = CLKS_PER_BIT/2 (integer division), clear bit_cnt, clear rdy and frm_err, go to RECV.
  - RECV:
    - baud_cnt decrements each clock.
    - When baud_cnt == 1 (sample point): sample rx_s2, reload baud_cnt = CLKS_PER_BIT, increment bit_cnt.
  - Sample 0 (start bit) == 1: false start. Go to IDLE; rdy, frm_err and rx_data are unchanged.
  - Samples 1..8 are data bits 0..7. Sample 9 is the stop bit.
  - After sample 9: go to IDLE.
    - Stop == 1: rx_data ← data bits and set rdy.
    - Stop == 0: set frm_err; rdy stays 0 and rx_data is unchanged.
- No re-arm is possible while the line stays low after a framing error, because fall requires a high→low transition.
- rdy and frm_err are sticky. They clear on clr_rdy or at the next start (fall in IDLE).
- If a set and clr_rdy occur in the same cycle, the set wins.
- clr_rdy has no effect on the FSM or on rx_data.
- In RECV, fall is ignored; a glitch mid-frame does not restart the frame.

## Timing
- Reset values: rdy=0, frm_err=0, rx_data=8'h00, state IDLE, synchronizer flops = 1.
- RX→rx_s2 latency is 2 clocks; fall is seen in cycle E, 3 clocks after the RX pin falls.
- Sample k (k=0..9) is taken in cycle E + CLKS_PER_BIT/2 + k·CLKS_PER_BIT.
- rdy or frm_err is high starting in cycle E + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1. rx_data is valid in that same cycle.
- Defaults: sample 0 is taken at E+1302, and rdy rises at E+24739.
- A back-to-back frame works: a start edge arriving right after a stop bit (no idle gap beyond the stop bit) is caught. The FSM is back in IDLE half a bit before the stop bit ends.
- rst asserted mid-frame: on the next edge the block returns to IDLE with all outputs at reset values. No rdy is produced for the partial frame.
- Tolerance: ±4% total baud mismatch, inherent in mid-bit sampling.

## Test plan
- Use CLKS_PER_BIT=16 unless noted.
- Send 8'hA5 with a good stop bit -> rdy=1 exactly 3+8+144+1 clocks after RX falls, rx_data=8'hA5, frm_err=0. Pulse clr_rdy -> rdy=0 next cycle, rx_data stays 8'hA5.
- Drive RX low for 4 clocks, then high (false start) -> FSM returns to IDLE after sample 0. rdy=0, frm_err=0, rx_data unchanged.
- Send 8'h3C with stop=0 -> frm_err=1, rdy=0, rx_data keeps the prior value. Hold RX low for 100 clocks -> no new frame starts. Release RX, then send 8'h81 -> frm_err clears at the start edge, and rdy=1 with rx_data=8'h81.
- Loop back from the team's UART transmitter at the default 2604 clocks/bit, sending bytes 8'h00, 8'hFF, 8'h55 back-to-back -> each is received in order with rdy pulses. Drive clr_rdy in the same cycle rdy sets -> rdy=1 (set wins).
- Assert rst for 1 clock during data bit 4 of a frame -> outputs return to reset values and no rdy results from that frame. The next full frame, 8'h7E, is received correctly.
